xbar_switch_rr: RTL
===================

// Module: xbar_switch_rr
//
// PURPOSE
// Parametrised registered NxN crossbar for the mesh router datapath. Each input
// presents one flit with a destination output index. Each output runs its own
// round-robin arbiter over the inputs that request it. A one-entry output
// register per port provides valid/ready flow control to downstream links.
// Generalises the fixed 5x5 combinational select-driven crossbar to N ports,
// adding arbitration and backpressure.
//
// PARAMETERS
// PORTS       5    number of input ports = number of output ports (>= 2)
// DATA_WIDTH  64   flit width in bits
// DEST_W      $clog2(PORTS)  localparam; width of each destination index
//
// PORTS
// clk          in   1                    single clock, rising edge
// reset        in   1                    synchronous, active-high
// in_data      in   [PORTS][DATA_WIDTH]  input flit per port
// in_valid     in   [PORTS]              input flit present
// in_dest      in   [PORTS][DEST_W]      requested output index per input
// in_ready     out  [PORTS]              flit on input i accepted this cycle
// out_data     out  [PORTS][DATA_WIDTH]  registered output flit per port
// out_valid    out  [PORTS]              output register holds a flit
// out_ready    in   [PORTS]              downstream accepts out_data[j]
// drop         out  [PORTS]              1-cycle pulse: input i flit discarded (illegal dest)
//
// BEHAVIOUR
// - Reset (sync, high): out_valid=0, out_data=0, drop=0, all RR pointers=0.
//   in_ready forced to 0 while reset is high.
// - Output j can load (ld[j]) when !out_valid[j] || out_ready[j].
// - Request req[j][i] = in_valid[i] && in_dest[i]==j (j < PORTS).
// - Arbiter j: when ld[j], grant the first requesting i searching from ptr[j]
//   upward, wrapping PORTS-1 -> 0. At most one grant per output per cycle.
//   Each input requests exactly one output, so no input receives two grants.
// - in_ready[i] = grant to i from any output, or illegal dest (below).
//   Combinational from in_valid/in_dest/out_ready/state; no cycle through in_ready.
// - On grant j<-i at edge: out_data[j]<=in_data[i], out_valid[j]<=1, ptr[j]<=(i+1)%PORTS.
// - Output j with no grant and ld[j]: out_valid[j]<=0, out_data[j]<=0.
//   out_data is zero whenever out_valid is 0.
// - Output j with !ld[j] (valid && !ready): out_data/out_valid hold stable;
//   no grant; ptr[j] unchanged.
// - Latency: accept at edge N -> out_valid at N+1. Throughput: 1 flit/cycle/output.
//   Back-to-back flits stream when out_ready stays 1.
// - Illegal dest (in_dest[i] >= PORTS, only reachable if PORTS not power of 2):
//   in_ready[i]=1 and the flit is consumed. drop[i]<=1 for one cycle; no output affected.
// - ptr[j] advances only on a grant by arbiter j. Idle outputs keep their pointer.
// - Reset mid-operation: in-flight output flits are discarded (out_valid->0).
//   Pointers return to 0; first grants after reset favour the lowest requesting index.
// - Inputs are assumed stable while in_valid && !in_ready (upstream obligation).
//   The switch does not buffer unaccepted input flits.
//
// TESTING
// 1 Reset: reset=1 for 3 cycles, all in_valid=1 -> out_valid=0, out_data=0,
//   in_ready=0 throughout; first cycle after reset grants begin.
// 2 Permutation: PORTS=5, in_dest[i]=(i+1)%5, in_data[i]=64'hA0+i, out_ready=all 1
//   -> in_ready=5'b11111; next cycle out_data[(i+1)%5]=A0+i, out_valid=all 1.
// 3 Contention: inputs 0,2,4 to output 3 continuously, out_ready[3]=1
//   -> grants cycle 0,2,4,0,2,4; out_data[3] sequence matches; each input 1/3 rate.
// 4 Backpressure: out_valid[1]=1 with out_ready[1]=0 for 4 cycles, input 2 -> dest 1
//   -> out_data[1] stable and in_ready[2]=0; raise out_ready[1] -> input 2 granted,
//   appears next cycle.
// 5 Illegal dest: in_dest[3]=6 with in_valid[3]=1 -> in_ready[3]=1, drop[3] pulses
//   for 1 cycle; no out_valid change.
// 6 Reset mid-run: during test 3 after grant to 2, pulse reset -> out_valid=0;
//   after release, first grant for output 3 goes to input 0.

Source files
------------

// File: rtl/xbar_switch_rr.sv
// Registered NxN crossbar with one round-robin arbiter per output.
// Each input offers one flit and a destination index. Each output holds a
// one-entry register that gives valid/ready flow control to the downstream
// link. A flit with an out-of-range destination is consumed and flagged on
// drop for one cycle, and no output is affected by it.
module xbar_switch_rr #(
    parameter int PORTS      = 5,
    parameter int DATA_WIDTH = 64,
    localparam int DEST_W    = $clog2(PORTS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [PORTS-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic [PORTS-1:0]                  in_valid,
    input  logic [PORTS-1:0][DEST_W-1:0]      in_dest,
    output logic [PORTS-1:0]                  in_ready,
    output logic [PORTS-1:0][DATA_WIDTH-1:0]  out_data,
    output logic [PORTS-1:0]                  out_valid,
    input  logic [PORTS-1:0]                  out_ready,
    output logic [PORTS-1:0]                  drop
);

    logic [PORTS-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [PORTS-1:0]                 out_valid_q, out_valid_d;
    logic [PORTS-1:0]                 drop_q, drop_d;
    logic [PORTS-1:0][DEST_W-1:0]     ptr_q, ptr_d;

    logic [PORTS-1:0]                 ld_s;
    logic [PORTS-1:0]                 illegal_s;
    logic [PORTS-1:0][PORTS-1:0]      req_s;        // req_s[output][input]
    logic [PORTS-1:0]                 grant_vld_s;
    logic [PORTS-1:0][DEST_W-1:0]     grant_idx_s;
    logic [PORTS-1:0]                 in_grant_s;
    logic [DEST_W-1:0]                cand_s;

    // Decode per-output requests, illegal destinations and output load enables.
    always_comb begin
        ld_s      = '0;
        illegal_s = '0;
        req_s     = '0;
        for (int i = 0; i < PORTS; i++) begin
            illegal_s[i] = in_valid[i] && (int'(in_dest[i]) >= PORTS);
            for (int j = 0; j < PORTS; j++) begin
                req_s[j][i] = in_valid[i] && (int'(in_dest[i]) == j);
            end
        end
        for (int j = 0; j < PORTS; j++) begin
            ld_s[j] = !out_valid_q[j] || out_ready[j];
        end
    end

    // Round-robin search from each output's pointer; first requester wins.
    always_comb begin
        grant_vld_s = '0;
        grant_idx_s = '0;
        in_grant_s  = '0;
        cand_s      = '0;
        for (int j = 0; j < PORTS; j++) begin
            for (int k = 0; k < PORTS; k++) begin
                cand_s = DEST_W'((int'(ptr_q[j]) + k) % PORTS);
                if (ld_s[j] && !grant_vld_s[j] && req_s[j][cand_s]) begin
                    grant_vld_s[j] = 1'b1;
                    grant_idx_s[j] = cand_s;
                end else begin
                    grant_vld_s[j] = grant_vld_s[j];
                end
            end
        end
        // An input asks for a single output, so it can collect at most one grant.
        for (int j = 0; j < PORTS; j++) begin
            if (grant_vld_s[j]) begin
                in_grant_s[grant_idx_s[j]] = 1'b1;
            end else begin
                in_grant_s = in_grant_s;
            end
        end
    end

    // Accept granted or illegal-destination flits; accept nothing during reset.
    always_comb begin
        in_ready = '0;
        if (reset) begin
            in_ready = '0;
        end else begin
            in_ready = in_grant_s | illegal_s;
        end
    end

    // Next state of the output registers, arbiter pointers and drop pulses.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        drop_d      = illegal_s;
        for (int j = 0; j < PORTS; j++) begin
            if (grant_vld_s[j]) begin
                out_data_d[j]  = in_data[grant_idx_s[j]];
                out_valid_d[j] = 1'b1;
                ptr_d[j]       = DEST_W'((int'(grant_idx_s[j]) + 1) % PORTS);
            end else if (ld_s[j]) begin
                // Output drained with nothing new: keep data at zero while invalid.
                out_data_d[j]  = '0;
                out_valid_d[j] = 1'b0;
            end else begin
                out_data_d[j]  = out_data_q[j];
                out_valid_d[j] = out_valid_q[j];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            drop_q      <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign drop      = drop_q;

endmodule
